// File: rtl/toggle_cover_monitor.sv
// rtl/toggle_cover_monitor.sv - rise/fall toggle coverage monitor with clear handshake
module toggle_cover_monitor #(
  parameter  int SIG_WIDTH      = 10,
  parameter  bit FIRST_HIT_ONLY = 1'b1,
  localparam int NPTS           = 2 * SIG_WIDTH,
  localparam int CW             = $clog2(NPTS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SIG_WIDTH-1:0] signal,
  input  logic                 sample_en,
  input  logic                 clear_req,
  output logic [NPTS-1:0]      valid,
  output logic [CW-1:0]        hit_count,
  output logic                 all_covered,
  output logic                 clear_ack,
  output logic                 primed
);

  typedef enum logic [1:0] {PRIME, RUN, ACK} state_e;

  localparam logic [CW-1:0] NPTS_C = CW'(NPTS);

  state_e                 state_q, state_d;
  logic [SIG_WIDTH-1:0]   prev_q, prev_d;
  logic [NPTS-1:0]        bitmap_q, bitmap_d;
  logic [NPTS-1:0]        valid_q, valid_d;
  logic [CW-1:0]          hit_q, hit_d;
  logic                   all_q, all_d;
  logic [NPTS-1:0]        det, newpts, merged;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME:   if (sample_en) state_d = RUN;
      RUN:     if (clear_req) state_d = ACK;
      ACK:     if (!clear_req) state_d = PRIME;
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    clear_ack = (state_q == ACK);
    primed    = (state_q == RUN);
  end

  // Even index = rise of signal[i], odd index = fall of signal[i].
  always_comb begin
    det = '0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      det[2*i]   = signal[i] & ~prev_q[i];
      det[2*i+1] = ~signal[i] & prev_q[i];
    end
    newpts = FIRST_HIT_ONLY ? (det & ~bitmap_q) : det;
    merged = bitmap_q | newpts;
    cnt    = '0;
    for (int k = 0; k < NPTS; k++) begin
      cnt = cnt + {{(CW-1){1'b0}}, merged[k]};
    end
  end

  // A clear takes priority over a coincident sample; the sample is dropped.
  always_comb begin
    prev_d   = prev_q;
    bitmap_d = bitmap_q;
    valid_d  = '0;
    hit_d    = hit_q;
    all_d    = all_q;
    if (state_q == RUN && clear_req) begin
      bitmap_d = '0;
      hit_d    = '0;
      all_d    = 1'b0;
    end else if (state_q == RUN && sample_en) begin
      prev_d   = signal;
      valid_d  = newpts;
      bitmap_d = merged;
      hit_d    = cnt;
      all_d    = (cnt == NPTS_C);
    end else if (state_q == PRIME && sample_en) begin
      prev_d = signal;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_q   <= '0;
      bitmap_q <= '0;
      valid_q  <= '0;
      hit_q    <= '0;
      all_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      bitmap_q <= bitmap_d;
      valid_q  <= valid_d;
      hit_q    <= hit_d;
      all_q    <= all_d;
    end
  end

  assign valid       = valid_q;
  assign hit_count   = hit_q;
  assign all_covered = all_q;

endmodule

// File: tb/tb_toggle_cover_monitor.sv
// tb/tb_toggle_cover_monitor.sv - directed bench for toggle_cover_monitor in both report modes
module tb_toggle_cover_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  signal = '0;
  logic        sample_en = 1'b0;
  logic        clear_req = 1'b0;

  logic [19:0] v0, v1;
  logic [4:0]  h0, h1;
  logic        a0, a1, ca0, ca1, p0, p1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  toggle_cover_monitor #(.SIG_WIDTH(10), .FIRST_HIT_ONLY(1'b1)) u_fho (
    .clock(clock), .reset(reset), .signal(signal), .sample_en(sample_en),
    .clear_req(clear_req), .valid(v0), .hit_count(h0), .all_covered(a0),
    .clear_ack(ca0), .primed(p0)
  );

  toggle_cover_monitor #(.SIG_WIDTH(10), .FIRST_HIT_ONLY(1'b0)) u_all (
    .clock(clock), .reset(reset), .signal(signal), .sample_en(sample_en),
    .clear_req(clear_req), .valid(v1), .hit_count(h1), .all_covered(a1),
    .clear_ack(ca1), .primed(p1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic [9:0] s);
    signal    = s;
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    sample_en = 1'b0;
    clear_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    vectors++;
    if ({v0, h0, a0, ca0, p0} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_fho: got v=%h h=%0d a=%b ca=%b p=%b, want all zero", v0, h0, a0, ca0, p0);
    end
    vectors++;
    if ({v1, h1, a1, ca1, p1} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_all: got v=%h h=%0d a=%b ca=%b p=%b, want all zero", v1, h1, a1, ca1, p1);
    end
    reset = 1'b1;
  endtask

  task automatic test_prime();
    sample(10'h3FF);
    vectors++;
    if (v0 !== 20'h0 || p0 !== 1'b1 || h0 !== 5'd0) begin
      miscompares++;
      $display("FAIL prime_first: got v=%h p=%b h=%0d, want v=0 p=1 h=0", v0, p0, h0);
    end
    sample(10'h000);
    vectors++;
    if (v0 !== 20'hAAAAA || h0 !== 5'd10) begin
      miscompares++;
      $display("FAIL prime_falls: got v=%h h=%0d, want v=aaaaa h=10", v0, h0);
    end
    vectors++;
    if (v1 !== 20'hAAAAA || h1 !== 5'd10) begin
      miscompares++;
      $display("FAIL prime_falls_all: got v=%h h=%0d, want v=aaaaa h=10", v1, h1);
    end
    tick();
    vectors++;
    if (v0 !== 20'h0 || h0 !== 5'd10) begin
      miscompares++;
      $display("FAIL valid_one_cycle: got v=%h h=%0d, want v=0 h=10", v0, h0);
    end
  endtask

  task automatic test_first_hit();
    int r0 = 0, f0 = 0, r1 = 0;
    logic [9:0] seq [4] = '{10'h0, 10'h1, 10'h0, 10'h1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sample(seq[i]);
      r0 += int'(v0[0]);
      f0 += int'(v0[1]);
      r1 += int'(v1[0]);
    end
    vectors++;
    if (r0 !== 1 || f0 !== 1) begin
      miscompares++;
      $display("FAIL first_hit_pulses: got rise=%0d fall=%0d, want 1 1", r0, f0);
    end
    vectors++;
    if (h0 !== 5'd2) begin
      miscompares++;
      $display("FAIL first_hit_count: got %0d, want 2", h0);
    end
    vectors++;
    if (r1 !== 2 || h1 !== 5'd2) begin
      miscompares++;
      $display("FAIL every_toggle: got rise=%0d h=%0d, want 2 2", r1, h1);
    end
  endtask

  task automatic test_clear_during_toggle();
    signal    = 10'h000;
    sample_en = 1'b1;
    clear_req = 1'b1;
    tick();
    vectors++;
    if (v0 !== 20'h0 || h0 !== 5'd0 || ca0 !== 1'b1 || p0 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_edge: got v=%h h=%0d ca=%b p=%b, want v=0 h=0 ca=1 p=0", v0, h0, ca0, p0);
    end
    tick();
    vectors++;
    if (ca0 !== 1'b1 || v0 !== 20'h0) begin
      miscompares++;
      $display("FAIL ack_hold: got ca=%b v=%h, want ca=1 v=0", ca0, v0);
    end
    sample_en = 1'b0;
    clear_req = 1'b0;
    tick();
    vectors++;
    if (ca0 !== 1'b0 || p0 !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_release: got ca=%b p=%b, want ca=0 p=0", ca0, p0);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    vectors++;
    if (ca0 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_in_prime: got ca=%b, want 0", ca0);
    end
    sample(10'h3FF);
    vectors++;
    if (v0 !== 20'h0 || p0 !== 1'b1 || h0 !== 5'd0) begin
      miscompares++;
      $display("FAIL reprime: got v=%h p=%b h=%0d, want v=0 p=1 h=0", v0, p0, h0);
    end
    sample(10'h3FE);
    vectors++;
    if (v0 !== 20'h00002 || h0 !== 5'd1) begin
      miscompares++;
      $display("FAIL after_clear: got v=%h h=%0d, want v=00002 h=1", v0, h0);
    end
  endtask

  task automatic test_full_cover();
    do_reset();
    sample(10'h000);
    sample(10'h3FF);
    vectors++;
    if (v0 !== 20'h55555 || h0 !== 5'd10 || a0 !== 1'b0) begin
      miscompares++;
      $display("FAIL half_cover: got v=%h h=%0d a=%b, want v=55555 h=10 a=0", v0, h0, a0);
    end
    sample(10'h000);
    vectors++;
    if (v0 !== 20'hAAAAA || h0 !== 5'd20 || a0 !== 1'b1) begin
      miscompares++;
      $display("FAIL full_cover: got v=%h h=%0d a=%b, want v=aaaaa h=20 a=1", v0, h0, a0);
    end
    sample(10'h3FF);
    vectors++;
    if (v0 !== 20'h0 || h0 !== 5'd20 || a0 !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate: got v=%h h=%0d a=%b, want v=0 h=20 a=1", v0, h0, a0);
    end
    vectors++;
    if (v1 !== 20'h55555 || h1 !== 5'd20 || a1 !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate_all: got v=%h h=%0d a=%b, want v=55555 h=20 a=1", v1, h1, a1);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    sample(10'h000);
    sample(10'h07F);
    vectors++;
    if (v0 !== 20'h01555 || h0 !== 5'd7) begin
      miscompares++;
      $display("FAIL pre_reset: got v=%h h=%0d, want v=01555 h=7", v0, h0);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({v0, h0, a0, ca0, p0} !== 29'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%h h=%0d a=%b ca=%b p=%b, want all zero", v0, h0, a0, ca0, p0);
    end
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (v0 !== 20'h0 || p0 !== 1'b0) begin
      miscompares++;
      $display("FAIL post_release: got v=%h p=%b, want v=0 p=0", v0, p0);
    end
    sample(10'h3FF);
    vectors++;
    if (v0 !== 20'h0 || p0 !== 1'b1 || h0 !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_prime: got v=%h p=%b h=%0d, want v=0 p=1 h=0", v0, p0, h0);
    end
    clear_req = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (ca0 !== 1'b0 || p0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ack: got ca=%b p=%b, want 0 0", ca0, p0);
    end
    clear_req = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_prime();
    test_first_hit();
    test_clear_during_toggle();
    test_full_cover();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
